// File: rtl/sa_drain_collector.sv
// sa_drain_collector: deskews the systolic array's bottom-row psum lanes into rows and queues them in a FIFO
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   in_c, in_valid : skewed psum lanes (lane j lags lane 0 by j cycles), in_valid marks lane 0 of a row
//   out_row, out_valid, out_ready : head-of-FIFO row with valid/ready handshake
//   count          : FIFO occupancy in rows
//   overflow       : sticky, set when a completed row is dropped on a full FIFO
//   SA_DRAIN_CLIP_EN : when defined, each lane saturates to 2*SIZE bits before the FIFO write
module sa_drain_collector #(
  parameter int SIZE  = 8,
  parameter int COLS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [COLS*(2*SIZE+1)-1:0]      in_c,
  input  logic                            in_valid,
  output logic [COLS*(2*SIZE+1)-1:0]      out_row,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            overflow
);
  localparam int PSW = 2*SIZE+1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW+1;
  localparam int RW  = COLS*PSW;

  function automatic logic [PSW-1:0] clip(input logic [PSW-1:0] v);
`ifdef SA_DRAIN_CLIP_EN
    return v[PSW-1] ? {1'b0, {(PSW-1){1'b1}}} : v;
`else
    return v;
`endif
  endfunction

  logic [COLS-2:0] vp;
  logic            row_done;
  logic [RW-1:0]   row;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [CW-1:0]   cnt;
  logic            pop, full, wr;

  assign row_done = vp[COLS-2];

  always_ff @(posedge clk)
    if (reset) vp <= '0;
    else vp <= (vp << 1) | (COLS-1)'(in_valid);

  // lane j waits COLS-1-j cycles so every lane of a row lines up with the last lane
  for (genvar j = 0; j < COLS-1; j++) begin : g_dly
    logic [PSW-1:0] sr [COLS-1-j];
    always_ff @(posedge clk)
      if (reset) sr <= '{default: '0};
      else begin
        sr[0] <= in_c[j*PSW +: PSW];
        for (int k = 1; k < COLS-1-j; k++) sr[k] <= sr[k-1];
      end
    assign row[j*PSW +: PSW] = clip(sr[COLS-2-j]);
  end
  assign row[(COLS-1)*PSW +: PSW] = clip(in_c[(COLS-1)*PSW +: PSW]);

  assign pop       = out_valid & out_ready;
  assign full      = cnt == CW'(DEPTH);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the row
  assign wr        = row_done & (~full | pop);
  assign out_valid = cnt != '0;
  assign out_row   = mem[rp];
  assign count     = cnt;

  always_ff @(posedge clk)
    if (wr) mem[wp] <= row;

  always_ff @(posedge clk)
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + CW'(wr) - CW'(pop);
      if (row_done & full & ~pop) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_sa_drain_collector.sv
// tb_sa_drain_collector: vector table, directed corner sequences and random traffic against a queue model
module tb_sa_drain_collector;
  localparam int SIZE = 8, COLS = 4, DEPTH = 4;
  localparam int PSW = 2*SIZE+1, CW = $clog2(DEPTH)+1, W = COLS*PSW, MAXC = 1200;

  logic          clk = 1'b0, reset, in_valid, out_valid, out_ready, overflow;
  logic [W-1:0]  in_c, out_row;
  logic [CW-1:0] count;

  sa_drain_collector #(.SIZE(SIZE), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_c(in_c), .in_valid(in_valid), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready), .count(count), .overflow(overflow));

  always #5 clk = ~clk;

  bit           rv [MAXC];
  bit           rr [MAXC];
  bit           rs [MAXC];
  logic [PSW-1:0] rd [MAXC][COLS];
  logic [W-1:0] q [$];
  bit           ovf;
  int           last_rst = -100;
  int           cyc = 0;
  int           checks = 0, failures = 0;

  typedef struct packed { logic [W-1:0] lanes; logic [W-1:0] exp; } vec_t;
  vec_t tv [3];

  function automatic logic [PSW-1:0] clip(input logic [PSW-1:0] v);
`ifdef SA_DRAIN_CLIP_EN
    return (v >= PSW'(2**(2*SIZE))) ? PSW'(2**(2*SIZE) - 1) : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [W-1:0] row_of(input int t);
    logic [W-1:0] r;
    for (int j = 0; j < COLS; j++) r[j*PSW +: PSW] = clip(rd[t][j]);
    return r;
  endfunction

  function automatic logic [W-1:0] pack_burst(input int base, input int k);
    logic [W-1:0] r;
    for (int j = 0; j < COLS; j++) r[j*PSW +: PSW] = PSW'(base + 16*k + j);
    return r;
  endfunction

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cycle=%0d: got %0h expected %0h", n, cyc, a, e);
    end
  endtask

  task automatic step();
    bit pop, push;
    reset     = rs[cyc];
    in_valid  = rv[cyc];
    out_ready = rr[cyc];
    for (int j = 0; j < COLS; j++)
      in_c[j*PSW +: PSW] = (cyc >= j && rv[cyc-j]) ? rd[cyc-j][j] : PSW'($urandom);
    @(posedge clk);
    if (rs[cyc]) begin
      q.delete();
      ovf = 1'b0;
      last_rst = cyc;
    end else begin
      pop  = q.size() > 0 && rr[cyc];
      push = cyc >= COLS-1 && rv[cyc-COLS+1] && last_rst < cyc-COLS+1;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(row_of(cyc-COLS+1));
        else ovf = 1'b1;
      end
    end
    #1;
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("count", 128'(count), 128'(q.size()));
    chk("overflow", 128'(overflow), 128'(ovf));
    if (q.size() > 0) chk("out_row", 128'(out_row), 128'(q[0]));
    cyc++;
  endtask

  task automatic run_to(input int e);
    while (cyc <= e) step();
  endtask

  task automatic put_row(input int c, input logic [W-1:0] lanes);
    rv[c] = 1'b1;
    for (int j = 0; j < COLS; j++) rd[c][j] = lanes[j*PSW +: PSW];
  endtask

  initial begin
    int b;
    tv[0] = '{lanes: {17'h00044, 17'h00033, 17'h00022, 17'h00011},
              exp:   {17'h00044, 17'h00033, 17'h00022, 17'h00011}};
`ifdef SA_DRAIN_CLIP_EN
    tv[1] = '{lanes: {17'h00001, 17'h00000, 17'h0FFFF, 17'h1FFFF},
              exp:   {17'h00001, 17'h00000, 17'h0FFFF, 17'h0FFFF}};
    tv[2] = '{lanes: {17'h10000, 17'h1ABCD, 17'h0FFFE, 17'h1FFFF},
              exp:   {17'h0FFFF, 17'h0FFFF, 17'h0FFFE, 17'h0FFFF}};
`else
    tv[1] = '{lanes: {17'h00001, 17'h00000, 17'h0FFFF, 17'h1FFFF},
              exp:   {17'h00001, 17'h00000, 17'h0FFFF, 17'h1FFFF}};
    tv[2] = '{lanes: {17'h10000, 17'h1ABCD, 17'h0FFFE, 17'h1FFFF},
              exp:   {17'h10000, 17'h1ABCD, 17'h0FFFE, 17'h1FFFF}};
`endif
    rs[0] = 1'b1;
    rs[1] = 1'b1;
    run_to(1);
    chk("reset_valid", 128'(out_valid), 128'(0));
    chk("reset_count", 128'(count), 128'(0));
    b = cyc;
    for (int i = 0; i < 3; i++) begin
      rs[b] = 1'b1;
      put_row(b+1, tv[i].lanes);
      run_to(b+3);
      chk("tv_not_yet_valid", 128'(out_valid), 128'(0));
      run_to(b+4);
      chk("tv_valid", 128'(out_valid), 128'(1));
      chk("tv_row", 128'(out_row), 128'(tv[i].exp));
      chk("tv_count", 128'(count), 128'(1));
      b = cyc;
    end
    // burst of 6 rows into a 4-deep FIFO with no reader
    rs[b] = 1'b1;
    for (int k = 0; k < 6; k++) put_row(b+1+k, pack_burst(0, k));
    for (int c = b+11; c <= b+14; c++) rr[c] = 1'b1;
    run_to(b+10);
    chk("burst_count", 128'(count), 128'(4));
    chk("burst_overflow", 128'(overflow), 128'(1));
    for (int k = 0; k < 4; k++) begin
      chk("burst_drain_row", 128'(out_row), 128'(pack_burst(0, k)));
      step();
    end
    chk("burst_empty", 128'(count), 128'(0));
    chk("burst_overflow_sticky", 128'(overflow), 128'(1));
    b = cyc;
    // full FIFO with simultaneous push and pop
    rs[b] = 1'b1;
    for (int k = 0; k < 5; k++) put_row(b+1+k, pack_burst(100, k));
    rr[b+8] = 1'b1;
    run_to(b+7);
    chk("full_count", 128'(count), 128'(4));
    run_to(b+8);
    chk("pushpop_count", 128'(count), 128'(4));
    chk("pushpop_overflow", 128'(overflow), 128'(0));
    chk("pushpop_head", 128'(out_row), 128'(pack_burst(100, 1)));
    b = cyc;
    // continuous stream with the reader always ready
    rs[b] = 1'b1;
    for (int k = 0; k < 20; k++) put_row(b+1+k, pack_burst(500, k));
    for (int c = b+1; c <= b+30; c++) rr[c] = 1'b1;
    run_to(b+30);
    chk("stream_overflow", 128'(overflow), 128'(0));
    chk("stream_count", 128'(count), 128'(0));
    b = cyc;
    // reset two cycles after a row's in_valid
    rs[b] = 1'b1;
    put_row(b+1, pack_burst(900, 0));
    rs[b+3] = 1'b1;
    run_to(b+10);
    chk("midreset_valid", 128'(out_valid), 128'(0));
    chk("midreset_count", 128'(count), 128'(0));
    chk("midreset_overflow", 128'(overflow), 128'(0));
    b = cyc;
    // random traffic
    rs[b] = 1'b1;
    for (int c = b+1; c <= b+300; c++) begin
      rv[c] = $urandom_range(0, 9) < 6;
      rr[c] = $urandom_range(0, 1) == 1;
      rs[c] = $urandom_range(0, 99) == 0;
      for (int j = 0; j < COLS; j++)
        rd[c][j] = ($urandom_range(0, 3) == 0) ? PSW'(17'h10000 | $urandom) : PSW'($urandom);
    end
    run_to(b+305);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sa_drain_collector.md
# sa_drain_collector

Output-side collector for the weight-stationary systolic array. It receives the skewed partial-sum stream leaving the bottom row of PEs, one lane per column, where column j lags column 0 by j cycles. It deskews the lanes into complete result rows and buffers them in a small FIFO. Rows are delivered to the downstream writer over a valid/ready handshake. It sits between the array's bottom `out_c` ports and the result-store logic, and is the consumer counterpart of the PE psum chain.

## Interface
- `SIZE`, 8, operand width of the PEs; each psum lane is `2*SIZE+1` bits (PSW).
- `COLS`, 4, number of array columns (lanes), ≥2.
- `DEPTH`, 4, FIFO depth in rows, power of two, ≥2.
- `clk`  input  1  clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_c`  input  COLS*PSW  bottom-row psums; lane j at bits [j*PSW +: PSW].
- `in_valid`  input  1  marks lane 0 of a row valid this cycle; lane j of the same row is implied valid j cycles later.
- `out_row`  output  COLS*PSW  head-of-FIFO row, same lane packing.
- `out_valid`  output  1  FIFO non-empty.
- `out_ready`  input  1  downstream accepts `out_row` when high with `out_valid`.
- `count`  output  clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  output  1  sticky; a completed row was dropped because the FIFO was full.

## Operation
- Deskew: lane j passes through a (COLS-1-j)-stage register delay; lane COLS-1 is undelayed. `in_valid` passes through a COLS-1-stage delay (`row_done`).
- Capture: at the edge where `row_done` is high, the aligned row is {lane COLS-1 = current `in_c`, lanes j<COLS-1 = delayed values}.
- Back-to-back rows, with `in_valid` high every cycle, are supported at one row per cycle with no bubbles.
- Delay stages shift every cycle unconditionally. There is no stall of the array; backpressure is absorbed by the FIFO only.
- FIFO is a circular buffer with write pointer, read pointer and occupancy counter. Pointers wrap modulo DEPTH.
- Push when `row_done`. Pop when `out_valid && out_ready`.
- Push with FIFO full and no pop in the same cycle: row discarded, `overflow` set and held until reset, occupancy unchanged.
- Push and pop in the same cycle: both occur, including when full or when exactly one row is held. Occupancy is unchanged.
- Pop with FIFO empty cannot occur, because `out_valid` is low.
- Lane values are unsigned and are not modified, except as described under Configuration.

## Timing
- Reset, at any time including mid-row:
  - All delay stages, `row_done` pipeline, pointers and `count` go to 0.
  - `overflow` goes to 0; `out_valid` goes to 0.
  - In-flight rows are lost. `out_row` is don't-care while `out_valid` is 0.
- Row latency: `in_valid` sampled at edge t → row written at edge t+COLS-1 → `out_valid` high in the cycle after edge t+COLS-1, if the FIFO was empty.
- `out_valid` and `out_row` are driven from registers/memory with no combinational path from `in_c`/`in_valid`.
- `out_ready` affects only the pop at the next edge; `out_row` may be combinational from the read pointer.
- `out_row` stays stable while `out_valid && !out_ready`.
- `count` and `overflow` update at the same edge as the push/pop that changes them.

## Configuration
- `SA_DRAIN_CLIP_EN` defined:
  - Each lane is saturated to 2*SIZE bits before the FIFO write.
  - Any value ≥ 2^(2*SIZE) is stored as 2^(2*SIZE)-1, with the MSB of the lane forced to 0.
  - Values below that are passed unchanged.
- `SA_DRAIN_CLIP_EN` undefined: lanes are stored as full PSW-bit values.

## Test plan
- Single row, COLS=4, SIZE=8: lanes 0..3 = 0x00011, 0x00022, 0x00033, 0x00044, presented skewed with `in_valid` at cycle 0 → `out_valid` rises after edge 3; `out_row` lanes = 0x11, 0x22, 0x33, 0x44; `count`=1.
- Burst of 6 rows (row k, lane j = 16k+j), `in_valid` high for 6 cycles, `out_ready` low, DEPTH=4 →
  - Rows 0..3 stored, rows 4 and 5 dropped.
  - `overflow`=1, `count`=4.
  - After raising `out_ready`, rows 0..3 drain in order.
- Continuous stream with `out_ready`=1 → one row out per cycle, in order, `count` ≤1, `overflow` stays 0.
- FIFO full, push and pop in the same cycle → push accepted, `count` stays 4, no overflow, oldest row popped.
- Reset asserted 2 cycles after `in_valid` of a row → no row ever appears, `out_valid`=0, `count`=0, `overflow`=0.
- Lane value 0x1FFFF, then 0x0FFFF → with `SA_DRAIN_CLIP_EN`, stored 0x0FFFF and 0x0FFFF; without it, 0x1FFFF and 0x0FFFF.
